tea_cbc_sequencer: RTL and testbench
====================================

Name: tea_cbc_sequencer

Overview:
Block-chaining sequencer placed directly upstream of the TEA cipher core. It accepts 64-bit blocks (v0/v1) over a valid/ready stream and applies ECB or CBC chaining with a loadable IV. It drives the core with a start/done handshake and returns processed blocks on a valid/ready output stream. This allows the register file to stream multi-block messages without software performing XOR chaining.

Parameters:
TIMEOUT, 255, max cycles from core_start_o to core_done_i before abort (≥1)
CNT_W, 16, width of completed-block counter

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
ctx_load_i  in  1  pulse: load iv_i, mode_i, chain_en_i, clear blk_cnt_o and err_o (honoured only in IDLE)
mode_i  in  1  0=encrypt, 1=decrypt
chain_en_i  in  1  1=CBC, 0=ECB
iv_v0_i  in  32  IV upper word
iv_v1_i  in  32  IV lower word
in_valid_i  in  1  input block valid
in_ready_o  out  1  input block accepted when valid&ready
in_v0_i  in  32  input word 0
in_v1_i  in  32  input word 1
core_start_o  out  1  one-cycle start pulse to cipher core
core_dec_o  out  1  latched mode to core
core_v0_o  out  32  core operand word 0
core_v1_o  out  32  core operand word 1
core_done_i  in  1  core result valid (pulse)
core_v0_i  in  32  core result word 0
core_v1_i  in  32  core result word 1
out_valid_o  out  1  output block valid
out_ready_i  in  1  consumer ready
out_v0_o  out  32  output word 0
out_v1_o  out  32  output word 1
busy_o  out  1  state != IDLE
err_o  out  1  sticky timeout flag
blk_cnt_o  out  CNT_W  completed-block count

Behaviour:
- Reset: state=IDLE; chain=0; mode=0; chain_en=0; all outputs 0 except in_ready_o=1.
- States: IDLE -> ISSUE -> WAIT_CORE -> OUT_HOLD -> IDLE.
- IDLE: in_ready_o=1. On ctx_load_i, latch config and IV into chain; clear err_o and blk_cnt_o; in_ready_o drops for that cycle, and ctx_load_i has priority over a simultaneous input. Otherwise, on in_valid_i, capture the block and go to ISSUE.
- ISSUE (1 cycle): core_start_o=1. Operand = ECB or decrypt: input block; CBC encrypt: input XOR chain. core_v*_o holds the operand from ISSUE until the core is done.
- WAIT_CORE: timer increments each cycle. On core_done_i, compute result: CBC decrypt = core XOR chain, otherwise core. Register result to out_v*_o and go to OUT_HOLD. Chain update in CBC mode: encrypt chain<=core result; decrypt chain<=captured input. ECB leaves chain unchanged.
- If the timer reaches TIMEOUT without core_done_i: err_o=1, block is dropped, chain unchanged, go to IDLE. core_done_i in the same cycle as the timeout wins.
- core_done_i outside WAIT_CORE is ignored.
- OUT_HOLD: out_valid_o=1 with data stable until out_ready_i. On handshake, blk_cnt_o++ (wraps at 2^CNT_W), then go to IDLE.
- Latency: input accept at cycle N, core_start_o at N+1; core_done_i at M gives out_valid_o at M+1. Maximum throughput is one block per (core latency + 3) cycles.
- ctx_load_i outside IDLE is ignored. Mode and chain_en are changeable only via ctx_load_i.
- Reset mid-operation returns to the reset state immediately. A core_done_i arriving later is ignored.

Test Plan:
Bench core model returns operand XOR 64'hFFFF0000_FFFF0000, 3 cycles after start.
1. ECB encrypt, input 00000001_00000002 -> output FFFF0001_FFFF0002; blk_cnt_o=1; core_start_o 1 cycle after accept.
2. CBC encrypt, IV 11111111_22222222, two zero blocks -> outputs EEEE1111_DDDD2222 then 11111111_22222222; blk_cnt_o=2.
3. CBC decrypt, same IV, inputs EEEE1111_DDDD2222 then 11111111_22222222 -> outputs 00000000_00000000 twice.
4. Core model never asserts done, TIMEOUT=8 -> err_o=1 at 8 cycles after start, busy_o=0, no out_valid_o. Next ctx_load_i clears err_o.
5. Hold out_ready_i=0 for 10 cycles -> out_valid_o and data stable, in_ready_o=0, a second in_valid_i is not accepted. Release -> second block processed.
6. Assert wb_rst_i during WAIT_CORE -> next cycle all outputs at reset values. Late core_done_i produces no output. blk_cnt_o wrap check with CNT_W=2: after 4 blocks, blk_cnt_o=0.

Source files
------------

// File: rtl/tea_cbc_sequencer.sv
// rtl/tea_cbc_sequencer.sv - ECB/CBC block-chaining sequencer feeding a TEA cipher core
module tea_cbc_sequencer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             ctx_load_i,
    input  logic             mode_i,
    input  logic             chain_en_i,
    input  logic [31:0]      iv_v0_i,
    input  logic [31:0]      iv_v1_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_v0_i,
    input  logic [31:0]      in_v1_i,
    output logic             core_start_o,
    output logic             core_dec_o,
    output logic [31:0]      core_v0_o,
    output logic [31:0]      core_v1_o,
    input  logic             core_done_i,
    input  logic [31:0]      core_v0_i,
    input  logic [31:0]      core_v1_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_v0_o,
    output logic [31:0]      out_v1_o,
    output logic             busy_o,
    output logic             err_o,
    output logic [CNT_W-1:0] blk_cnt_o
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_CORE = 2'd2,
        OUT_HOLD  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [63:0]       chain_q, chain_d;
    logic [63:0]       blk_q, blk_d;
    logic [63:0]       op_q, op_d;
    logic [63:0]       out_q, out_d;
    logic              mode_q, mode_d;
    logic              cen_q, cen_d;
    logic              err_q, err_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [63:0]       in_blk, core_blk;

    assign in_blk   = {in_v0_i, in_v1_i};
    assign core_blk = {core_v0_i, core_v1_i};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            chain_q <= '0;
            blk_q   <= '0;
            op_q    <= '0;
            out_q   <= '0;
            mode_q  <= 1'b0;
            cen_q   <= 1'b0;
            err_q   <= 1'b0;
            timer_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            chain_q <= chain_d;
            blk_q   <= blk_d;
            op_q    <= op_d;
            out_q   <= out_d;
            mode_q  <= mode_d;
            cen_q   <= cen_d;
            err_q   <= err_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        chain_d = chain_q;
        blk_d   = blk_q;
        op_d    = op_q;
        out_d   = out_q;
        mode_d  = mode_q;
        cen_d   = cen_q;
        err_d   = err_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (ctx_load_i) begin
                    chain_d = {iv_v0_i, iv_v1_i};
                    mode_d  = mode_i;
                    cen_d   = chain_en_i;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end else if (in_valid_i) begin
                    blk_d   = in_blk;
                    // Only CBC encrypt whitens the operand; decrypt unchains after the core.
                    op_d    = (cen_q && !mode_q) ? (in_blk ^ chain_q) : in_blk;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = TW'(1);
                state_d = WAIT_CORE;
            end
            WAIT_CORE: begin
                if (core_done_i) begin
                    out_d = (cen_q && mode_q) ? (core_blk ^ chain_q) : core_blk;
                    if (cen_q) begin
                        chain_d = mode_q ? blk_q : core_blk;
                    end
                    state_d = OUT_HOLD;
                end else if (timer_q >= TLAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            OUT_HOLD: begin
                if (out_ready_i) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready_o   = (state_q == IDLE) && !ctx_load_i;
    assign core_start_o = (state_q == ISSUE);
    assign core_dec_o   = mode_q;
    assign core_v0_o    = op_q[63:32];
    assign core_v1_o    = op_q[31:0];
    assign out_valid_o  = (state_q == OUT_HOLD);
    assign out_v0_o     = out_q[63:32];
    assign out_v1_o     = out_q[31:0];
    assign busy_o       = (state_q != IDLE);
    assign err_o        = err_q;
    assign blk_cnt_o    = cnt_q;

endmodule

// File: tb/tb_tea_cbc_sequencer.sv
// tb/tb_tea_cbc_sequencer.sv - self-checking bench for tea_cbc_sequencer
module tb_tea_cbc_sequencer;

    localparam logic [63:0] MASK = 64'hFFFF0000_FFFF0000;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i, ctx_load_i, mode_i, chain_en_i;
    logic [31:0] iv_v0_i, iv_v1_i, in_v0_i, in_v1_i;
    logic        in_valid_i, in_ready_o, out_ready_i;
    logic        core_start_o, core_dec_o;
    logic [31:0] core_v0_o, core_v1_o, out_v0_o, out_v1_o;
    logic        core_done_i = 1'b0;
    logic [31:0] core_v0_i = '0, core_v1_i = '0;
    logic        out_valid_o, busy_o, err_o;
    logic [1:0]  blk_cnt_o;

    tea_cbc_sequencer #(.TIMEOUT(8), .CNT_W(2)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .ctx_load_i(ctx_load_i),
        .mode_i(mode_i), .chain_en_i(chain_en_i), .iv_v0_i(iv_v0_i), .iv_v1_i(iv_v1_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_v0_i(in_v0_i), .in_v1_i(in_v1_i),
        .core_start_o(core_start_o), .core_dec_o(core_dec_o),
        .core_v0_o(core_v0_o), .core_v1_o(core_v1_o), .core_done_i(core_done_i),
        .core_v0_i(core_v0_i), .core_v1_i(core_v1_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_v0_o(out_v0_o), .out_v1_o(out_v1_o),
        .busy_o(busy_o), .err_o(err_o), .blk_cnt_o(blk_cnt_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    logic hang = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Core stand-in: result = operand ^ MASK, done three cycles after start.
    logic        p1 = 1'b0, p2 = 1'b0;
    logic [63:0] r1 = '0, r2 = '0;
    always @(posedge wb_clk_i) begin
        p1 <= core_start_o && !hang;
        r1 <= {core_v0_o, core_v1_o} ^ MASK;
        p2 <= p1;
        r2 <= r1;
        core_done_i <= p2;
        {core_v0_i, core_v1_i} <= r2;
    end

    // Chaining model: expected operand/result computed at input acceptance.
    logic [63:0] m_chain = '0, last_out = '0;
    logic        m_mode = 1'b0, m_cen = 1'b0;
    logic [1:0]  m_cnt = '0;
    logic [63:0] opq[$];
    logic [63:0] expq[$];

    always @(posedge wb_clk_i) begin
        logic [63:0] inb, op, res;
        if (wb_rst_i) begin
            m_chain = '0; m_mode = 1'b0; m_cen = 1'b0; m_cnt = '0;
            opq.delete(); expq.delete();
        end else begin
            if (ctx_load_i) begin
                m_chain = {iv_v0_i, iv_v1_i}; m_mode = mode_i; m_cen = chain_en_i; m_cnt = '0;
            end else if (in_valid_i && in_ready_o) begin
                inb = {in_v0_i, in_v1_i};
                if (m_cen && !m_mode) begin
                    op = inb ^ m_chain; res = op ^ MASK;
                end else if (m_cen) begin
                    op = inb; res = (inb ^ MASK) ^ m_chain;
                end else begin
                    op = inb; res = inb ^ MASK;
                end
                opq.push_back(op);
                if (!hang) begin
                    expq.push_back(res);
                    if (m_cen) m_chain = m_mode ? inb : op ^ MASK;
                end
            end
            if (core_start_o && opq.size() > 0) void'(opq.pop_front());
            if (out_valid_o && out_ready_i) begin
                last_out = {out_v0_o, out_v1_o};
                if (expq.size() > 0) void'(expq.pop_front());
                m_cnt = m_cnt + 2'd1;
            end
        end
    end

    always @(negedge wb_clk_i) begin
        if (!wb_rst_i) begin
            if (out_valid_o) begin
                if (expq.size() == 0) fail_now("unexpected_out_valid");
                else chk("out_data", {out_v0_o, out_v1_o}, expq[0]);
                chk("in_ready_while_out", 64'(in_ready_o), 64'd0);
            end
            if (core_start_o) begin
                if (opq.size() == 0) fail_now("unexpected_core_start");
                else chk("core_operand", {core_v0_o, core_v1_o}, opq[0]);
            end
            chk("blk_cnt", 64'(blk_cnt_o), 64'(m_cnt));
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready_o), 64'd1);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid_o), 64'd0);
        chk({tag, "_core_start"}, 64'(core_start_o), 64'd0);
        chk({tag, "_err"}, 64'(err_o), 64'd0);
        chk({tag, "_blk_cnt"}, 64'(blk_cnt_o), 64'd0);
        chk({tag, "_core_v"}, {core_v0_o, core_v1_o}, 64'd0);
        chk({tag, "_out_v"}, {out_v0_o, out_v1_o}, 64'd0);
        chk({tag, "_core_dec"}, 64'(core_dec_o), 64'd0);
    endtask

    task automatic ctx(input logic m, input logic c, input logic [63:0] iv);
        ctx_load_i = 1'b1; mode_i = m; chain_en_i = c; {iv_v0_i, iv_v1_i} = iv;
        @(posedge wb_clk_i); #1;
        ctx_load_i = 1'b0;
    endtask

    // Returns #1 after the accepting edge, i.e. inside the ISSUE cycle.
    task automatic send(input logic [63:0] b);
        int n = 0;
        {in_v0_i, in_v1_i} = b;
        in_valid_i = 1'b1;
        @(negedge wb_clk_i);
        while (!in_ready_o && n < 200) begin @(negedge wb_clk_i); n++; end
        if (n >= 200) fail_now("send_accept");
        @(posedge wb_clk_i); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge wb_clk_i); n++; end
        while ((busy_o || expq.size() != 0) && n < 100);
        if (n >= 100) fail_now("wait_idle");
        @(posedge wb_clk_i); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        wb_rst_i = 1'b1; ctx_load_i = 1'b0; mode_i = 1'b0; chain_en_i = 1'b0;
        iv_v0_i = '0; iv_v1_i = '0; in_valid_i = 1'b0; in_v0_i = '0; in_v1_i = '0;
        out_ready_i = 1'b1;
        repeat (3) @(posedge wb_clk_i);
        #1;
        chk_reset("reset");
        wb_rst_i = 1'b0;

        // 1: ECB encrypt
        ctx(1'b0, 1'b0, 64'd0);
        send(64'h00000001_00000002);
        chk("t1_start_latency", 64'(core_start_o), 64'd1);
        wait_idle();
        chk("t1_out", last_out, 64'hFFFF0001_FFFF0002);
        chk("t1_cnt", 64'(blk_cnt_o), 64'd1);

        // 2: CBC encrypt
        ctx(1'b0, 1'b1, 64'h11111111_22222222);
        send(64'd0); wait_idle();
        chk("t2_out0", last_out, 64'hEEEE1111_DDDD2222);
        send(64'd0); wait_idle();
        chk("t2_out1", last_out, 64'h11111111_22222222);
        chk("t2_cnt", 64'(blk_cnt_o), 64'd2);

        // 3: CBC decrypt
        ctx(1'b1, 1'b1, 64'h11111111_22222222);
        chk("t3_dec", 64'(core_dec_o), 64'd1);
        send(64'hEEEE1111_DDDD2222); wait_idle();
        chk("t3_out0", last_out, 64'd0);
        last_out = 64'hDEAD;
        send(64'h11111111_22222222); wait_idle();
        chk("t3_out1", last_out, 64'd0);
        chk("t3_cnt", 64'(blk_cnt_o), 64'd2);

        // 4: timeout
        ctx(1'b0, 1'b0, 64'd0);
        hang = 1'b1;
        send(64'h12345678_9ABCDEF0);
        for (int k = 0; k < 8; k++) begin
            chk("t4_err_early", 64'(err_o), 64'd0);
            @(posedge wb_clk_i); #1;
        end
        chk("t4_err", 64'(err_o), 64'd1);
        chk("t4_busy", 64'(busy_o), 64'd0);
        hang = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        chk("t4_err_sticky", 64'(err_o), 64'd1);
        ctx(1'b0, 1'b0, 64'd0);
        chk("t4_err_cleared", 64'(err_o), 64'd0);

        // 5: output backpressure
        out_ready_i = 1'b0;
        send(64'hA5A5A5A5_0F0F0F0F);
        begin
            int n = 0;
            while (!out_valid_o && n < 50) begin @(negedge wb_clk_i); n++; end
            if (n >= 50) fail_now("t5_out_valid");
        end
        {in_v0_i, in_v1_i} = 64'h0000FFFF_12340000;
        in_valid_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge wb_clk_i);
            chk("t5_hold_valid", 64'(out_valid_o), 64'd1);
            chk("t5_hold_data", {out_v0_o, out_v1_o}, 64'h5A5AA5A5_F0F00F0F);
        end
        out_ready_i = 1'b1;
        begin
            int n = 0;
            while (!in_ready_o && n < 50) begin @(negedge wb_clk_i); n++; end
            if (n >= 50) fail_now("t5_second_accept");
        end
        @(posedge wb_clk_i); #1;
        in_valid_i = 1'b0;
        wait_idle();
        chk("t5_out1", last_out, 64'hFFFFFFFF_EDCB0000);
        chk("t5_cnt", 64'(blk_cnt_o), 64'd2);

        // 6: reset in WAIT_CORE, late done ignored, then counter wrap
        send(64'h00000003_00000004);
        @(posedge wb_clk_i); #1;
        chk("t6_busy_wait", 64'(busy_o), 64'd1);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        chk_reset("t6_rst");
        wb_rst_i = 1'b0;
        repeat (6) @(posedge wb_clk_i);
        #1;
        chk("t6_no_out", 64'(out_valid_o), 64'd0);
        chk("t6_idle", 64'(busy_o), 64'd0);
        ctx(1'b0, 1'b0, 64'd0);
        for (int i = 0; i < 4; i++) begin
            send(64'(i) << 8);
            wait_idle();
            if (i == 2) chk("t6_cnt3", 64'(blk_cnt_o), 64'd3);
        end
        chk("t6_wrap", 64'(blk_cnt_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
